tape_reader_feeder: RTL and testbench

- Upstream device-side stage of the input/output electronic unit. Host writes 5-bit tape codes into an internal FIFO; block replays them one code at a time over the unit's input four-phase handshake (input_rdy / input_val / input_data).
- Emulates photoreader timing with programmable data setup and hold. Reports FIFO level and transfer count to the panel/debug bus.

---
 rtl/tape_reader_feeder.sv | 160 ++++++++++++++++
 tb/tb_tape_reader_feeder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tape_reader_feeder.sv
// Tape reader feeder: buffers host tape codes and replays them over the unit's
// four-phase input handshake with programmable setup and inter-transfer gap.
module tape_reader_feeder #(
  parameter int DEPTH        = 16,
  parameter int SETUP_CYCLES = 2,
  parameter int GAP_CYCLES   = 3
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     host_valid,
  output logic                     host_ready,
  input  logic [4:0]               host_data,
  input  logic                     flush,
  input  logic                     input_rdy_from_io,
  output logic                     input_val_to_io,
  output logic [4:0]               input_data_to_io,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     busy,
  output logic [15:0]              codes_sent,
  output logic                     overflow
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CMAX  = (SETUP_CYCLES > GAP_CYCLES) ? SETUP_CYCLES : GAP_CYCLES;
  localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [AW-1:0]    PTR_ONE   = 1;
  localparam logic [AW:0]      LVL_ONE   = 1;
  localparam logic [AW:0]      LVL_FULL  = DEPTH;
  localparam logic [CNT_W-1:0] CNT_ONE   = 1;
  localparam logic [CNT_W-1:0] CNT_SETUP = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_GAP   = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {R_IDLE, R_SETUP, R_VAL, R_GAP} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             r_flush_pending;
  logic             r_overflow;
  logic             r_val;
  logic [4:0]       r_data;
  logic [15:0]      r_codes_sent;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_start;
  logic w_go_idle;
  logic w_clear;

  assign w_full  = (r_level == LVL_FULL);
  assign w_empty = (r_level == '0);

  assign host_ready = !w_full && !r_flush_pending;

  // A flush takes effect at once in R_IDLE; otherwise it waits until the
  // in-flight transfer finishes and the FSM re-enters R_IDLE.
  assign w_go_idle = ((r_state == R_SETUP) && !input_rdy_from_io) ||
                     ((r_state == R_GAP) && (r_cnt == '0));
  assign w_clear   = (flush || r_flush_pending) && ((r_state == R_IDLE) || w_go_idle);

  assign w_push  = host_valid && host_ready && !w_clear;
  assign w_pop   = (r_state == R_VAL) && !input_rdy_from_io;
  assign w_start = (r_state == R_IDLE) && input_rdy_from_io && !w_empty &&
                   !r_flush_pending && !flush;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= host_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_level         <= '0;
      r_flush_pending <= 1'b0;
      r_overflow      <= 1'b0;
      r_codes_sent    <= '0;
    end else begin
      if (w_clear) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        case ({w_push, w_pop})
          2'b10:   r_level <= r_level + LVL_ONE;
          2'b01:   r_level <= r_level - LVL_ONE;
          default: r_level <= r_level;
        endcase
      end

      if (w_clear)    r_flush_pending <= 1'b0;
      else if (flush) r_flush_pending <= 1'b1;

      if (host_valid && !host_ready && !r_flush_pending) r_overflow <= 1'b1;

      if (w_pop) r_codes_sent <= r_codes_sent + 16'd1;
    end
  end

  // Handshake FSM; data only changes when leaving R_IDLE so it is stable
  // across the whole setup and valid window.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= R_IDLE;
      r_cnt   <= '0;
      r_val   <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (w_start) begin
            r_data  <= r_mem[r_rd_ptr];
            r_cnt   <= CNT_SETUP;
            r_state <= R_SETUP;
          end
        end
        R_SETUP: begin
          if (!input_rdy_from_io) begin
            r_state <= R_IDLE;
          end else if (r_cnt == '0) begin
            r_val   <= 1'b1;
            r_state <= R_VAL;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        R_VAL: begin
          if (!input_rdy_from_io) begin
            r_val   <= 1'b0;
            r_cnt   <= CNT_GAP;
            r_state <= R_GAP;
          end
        end
        R_GAP: begin
          if (r_cnt == '0) r_state <= R_IDLE;
          else             r_cnt   <= r_cnt - CNT_ONE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign input_val_to_io  = r_val;
  assign input_data_to_io = r_data;
  assign fifo_level       = r_level;
  assign busy             = (r_state != R_IDLE);
  assign codes_sent       = r_codes_sent;
  assign overflow         = r_overflow;

endmodule

// File: tb/tb_tape_reader_feeder.sv
// Bench for tape_reader_feeder: directed scenarios with random codes, checked
// against a queue-based model of the code stream and handshake timing rules.
module tb_tape_reader_feeder;

  localparam int DEPTH = 16;
  localparam int SETUP = 2;
  localparam int GAP   = 3;
  localparam int BOUND = 40;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        host_valid = 1'b0;
  logic        host_ready;
  logic [4:0]  host_data = '0;
  logic        flush = 1'b0;
  logic        input_rdy_from_io = 1'b0;
  logic        input_val_to_io;
  logic [4:0]  input_data_to_io;
  logic [4:0]  fifo_level;
  logic        busy;
  logic [15:0] codes_sent;
  logic        overflow;

  tape_reader_feeder #(.DEPTH(DEPTH), .SETUP_CYCLES(SETUP), .GAP_CYCLES(GAP)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .host_valid        (host_valid),
    .host_ready        (host_ready),
    .host_data         (host_data),
    .flush             (flush),
    .input_rdy_from_io (input_rdy_from_io),
    .input_val_to_io   (input_val_to_io),
    .input_data_to_io  (input_data_to_io),
    .fifo_level        (fifo_level),
    .busy              (busy),
    .codes_sent        (codes_sent),
    .overflow          (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: queued codes, completed transfers, sticky overflow.
  logic [4:0] exp_q [$];
  int         sent;
  bit         ovf_m;
  int         last_fall;
  logic       prev_val;
  logic [4:0] rise_data;
  int         cyc;
  int         checks;
  int         errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick_raw();
    @(negedge clk);
    cyc++;
  endtask

  // Advance one cycle and watch the handshake for rise/hold/fall events.
  task automatic tick();
    tick_raw();
    if (input_val_to_io === 1'b1 && prev_val !== 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_val", {31'd0, input_val_to_io}, 32'd0);
      end else begin
        chk("rise_data", {27'd0, input_data_to_io}, {27'd0, exp_q[0]});
      end
      if (last_fall >= 0)
        chk("gap_min", {31'd0, (cyc - last_fall) >= (GAP + SETUP + 1)}, 32'd1);
      rise_data = input_data_to_io;
    end else if (input_val_to_io === 1'b1) begin
      chk("data_stable", {27'd0, input_data_to_io}, {27'd0, rise_data});
    end else if (prev_val === 1'b1) begin
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      sent++;
      last_fall = cyc;
      chk("codes_sent", {16'd0, codes_sent}, sent & 32'hFFFF);
    end
    prev_val = input_val_to_io;
  endtask

  task automatic push(input logic [4:0] d);
    logic r;
    r = host_ready;
    host_valid = 1'b1;
    host_data  = d;
    if (r && !flush) exp_q.push_back(d);
    else if (!r) ovf_m = 1'b1;
    tick();
    host_valid = 1'b0;
  endtask

  task automatic wait_rise(output int n);
    n = 0;
    while (input_val_to_io !== 1'b1 && n < BOUND) begin
      tick();
      n++;
    end
  endtask

  // Hold ready for 'hold' cycles of valid, then drop it and let the gap run out.
  task automatic finish_xfer(input int hold);
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("val_held", {31'd0, input_val_to_io}, 32'd1);
    end
    input_rdy_from_io = 1'b0;
    tick();
    chk("val_fall", {31'd0, input_val_to_io}, 32'd0);
    chk("busy_gap", {31'd0, busy}, 32'd1);
    repeat (GAP) tick();
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic deliver(input int hold);
    int n;
    input_rdy_from_io = 1'b1;
    wait_rise(n);
    chk("val_latency", n, SETUP + 1);
    finish_xfer(hold);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick_raw();
    resetn = 1'b1;
    exp_q.delete();
    sent      = 0;
    ovf_m     = 1'b0;
    last_fall = -1;
    prev_val  = 1'b0;
  endtask

  initial begin
    int n;
    checks = 0; errors = 0; cyc = 0;
    sent = 0; ovf_m = 1'b0; last_fall = -1; prev_val = 1'b0;

    // Reset values
    tick_raw();
    do_reset();
    chk("rst_host_ready", {31'd0, host_ready}, 32'd1);
    chk("rst_val", {31'd0, input_val_to_io}, 32'd0);
    chk("rst_data", {27'd0, input_data_to_io}, 32'd0);
    chk("rst_level", {27'd0, fifo_level}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_codes_sent", {16'd0, codes_sent}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);

    // Empty FIFO with ready high: stay idle
    input_rdy_from_io = 1'b1;
    repeat (5) tick();
    chk("idle_empty_busy", {31'd0, busy}, 32'd0);
    chk("idle_empty_val", {31'd0, input_val_to_io}, 32'd0);

    // Single code
    push(5'b10011);
    wait_rise(n);
    chk("single_latency", n, SETUP + 1);
    chk("single_data", {27'd0, input_data_to_io}, 32'h13);
    finish_xfer(1);
    chk("single_sent", {16'd0, codes_sent}, 32'd1);
    chk("single_level", {27'd0, fifo_level}, 32'd0);

    // Random codes with random valid hold times
    for (int i = 0; i < 6; i++) push(5'($urandom));
    chk("rand_level", {27'd0, fifo_level}, exp_q.size());
    for (int i = 0; i < 6; i++) deliver(int'($urandom_range(0, 3)));
    chk("rand_sent", {16'd0, codes_sent}, sent);
    chk("rand_level_end", {27'd0, fifo_level}, 32'd0);

    // Abort during setup
    push(5'($urandom));
    input_rdy_from_io = 1'b1;
    tick();
    chk("abort_busy", {31'd0, busy}, 32'd1);
    input_rdy_from_io = 1'b0;
    tick();
    chk("abort_idle", {31'd0, busy}, 32'd0);
    chk("abort_val", {31'd0, input_val_to_io}, 32'd0);
    chk("abort_level", {27'd0, fifo_level}, 32'd1);
    deliver(0);
    chk("abort_level_end", {27'd0, fifo_level}, 32'd0);

    // Burst of 16 with the unit re-asserting ready immediately
    for (int i = 0; i < 16; i++) push(5'(16 + i));
    chk("burst_full_ready", {31'd0, host_ready}, 32'd0);
    chk("burst_level", {27'd0, fifo_level}, 32'd16);
    input_rdy_from_io = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wait_rise(n);
      chk("burst_rise", {31'd0, input_val_to_io}, 32'd1);
      repeat (int'($urandom_range(0, 2))) tick();
      input_rdy_from_io = 1'b0;
      tick();
      chk("burst_fall", {31'd0, input_val_to_io}, 32'd0);
      input_rdy_from_io = 1'b1;
    end
    repeat (GAP + 1) tick();
    input_rdy_from_io = 1'b0;
    chk("burst_sent", {16'd0, codes_sent}, sent);
    chk("burst_count", sent, 32'd24);
    chk("burst_level_end", {27'd0, fifo_level}, 32'd0);

    // Flush mid-transfer
    for (int i = 0; i < 4; i++) push(5'($urandom));
    input_rdy_from_io = 1'b1;
    wait_rise(n);
    chk("flush_rise", {31'd0, input_val_to_io}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_pend_ready", {31'd0, host_ready}, 32'd0);
    chk("flush_val_kept", {31'd0, input_val_to_io}, 32'd1);
    chk("flush_level_kept", {27'd0, fifo_level}, 32'd4);
    finish_xfer(0);
    chk("flush_sent", {16'd0, codes_sent}, sent);
    chk("flush_level", {27'd0, fifo_level}, 32'd0);
    chk("flush_ready_back", {31'd0, host_ready}, 32'd1);
    exp_q.delete();
    input_rdy_from_io = 1'b1;
    repeat (8) tick();
    chk("flush_no_val", {31'd0, input_val_to_io}, 32'd0);
    input_rdy_from_io = 1'b0;

    // Flush in idle, racing a push
    for (int i = 0; i < 3; i++) push(5'($urandom));
    flush = 1'b1;
    push(5'($urandom));
    flush = 1'b0;
    exp_q.delete();
    chk("idle_flush_level", {27'd0, fifo_level}, 32'd0);
    chk("idle_flush_ready", {31'd0, host_ready}, 32'd1);

    // Overflow
    for (int i = 0; i < 16; i++) push(5'($urandom));
    chk("ovf_not_yet", {31'd0, overflow}, 32'd0);
    chk("ovf_ready_low", {31'd0, host_ready}, 32'd0);
    push(5'b00111);
    chk("ovf_set", {31'd0, overflow}, {31'd0, ovf_m});
    chk("ovf_level", {27'd0, fifo_level}, 32'd16);
    for (int i = 0; i < 16; i++) deliver(int'($urandom_range(0, 1)));
    input_rdy_from_io = 1'b1;
    repeat (8) tick();
    chk("ovf_17th_dropped", {31'd0, input_val_to_io}, 32'd0);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    input_rdy_from_io = 1'b0;

    // Reset while valid is high
    push(5'($urandom));
    push(5'($urandom));
    input_rdy_from_io = 1'b1;
    wait_rise(n);
    chk("rst_val_rise", {31'd0, input_val_to_io}, 32'd1);
    do_reset();
    input_rdy_from_io = 1'b0;
    chk("rstv_val", {31'd0, input_val_to_io}, 32'd0);
    chk("rstv_level", {27'd0, fifo_level}, 32'd0);
    chk("rstv_sent", {16'd0, codes_sent}, 32'd0);
    chk("rstv_overflow", {31'd0, overflow}, 32'd0);
    chk("rstv_busy", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
